// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I encodings for ALU op class, ALU control, funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_e;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Combinational RV32I integer ALU with zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_ctrl_e       alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0] w_shamt;
  assign w_shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << w_shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $signed(a) >>> w_shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module      : ex_mem_stage
// Description : RV32I execute stage: forwarding, ALU control, ALU, BEQ
//               resolution, registered into the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  beq_in,
  input  logic                  alu_src_in,
  input  logic [1:0]            alu_op_in,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [XLEN-1:0]       imm_in,
  input  logic [XLEN-1:0]       reg_a_in,
  input  logic [XLEN-1:0]       reg_b_in,
  input  logic [6:0]            funct7_in,
  input  logic [2:0]            funct3_in,
  input  logic [XLEN-1:0]       pc_in,
  input  logic                  memwb_reg_write_in,
  input  logic [REG_ADDR_W-1:0] memwb_rd_in,
  input  logic [XLEN-1:0]       memwb_data_in,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [XLEN-1:0]       alu_result_out,
  output logic [XLEN-1:0]       store_data_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  branch_taken_out,
  output logic [XLEN-1:0]       branch_target_out
);

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_zero;
  logic            w_exmem_fwd_ok;
  alu_ctrl_e       w_alu_ctrl;

  // A load in EX/MEM has no data yet; the hazard unit stalls instead.
  assign w_exmem_fwd_ok = reg_write_out && !mem_read_out && (rd_out != '0);

  always_comb begin
    w_fwd_a = reg_a_in;
    if (w_exmem_fwd_ok && (rd_out == rs1_in))
      w_fwd_a = alu_result_out;
    else if (memwb_reg_write_in && (memwb_rd_in != '0) && (memwb_rd_in == rs1_in))
      w_fwd_a = memwb_data_in;
  end

  always_comb begin
    w_fwd_b = reg_b_in;
    if (w_exmem_fwd_ok && (rd_out == rs2_in))
      w_fwd_b = alu_result_out;
    else if (memwb_reg_write_in && (memwb_rd_in != '0) && (memwb_rd_in == rs2_in))
      w_fwd_b = memwb_data_in;
  end

  assign w_op_b = alu_src_in ? imm_in : w_fwd_b;

  // I-type never subtracts (ADDI), but funct7[5] still selects SRAI.
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (alu_op_in)
      ALUOP_ADD: w_alu_ctrl = ALU_ADD;
      ALUOP_SUB: w_alu_ctrl = ALU_SUB;
      default: begin
        case (funct3_in)
          F3_ADD_SUB: w_alu_ctrl = ((alu_op_in == ALUOP_R) && funct7_in[5]) ? ALU_SUB : ALU_ADD;
          F3_SLL:     w_alu_ctrl = ALU_SLL;
          F3_SLT:     w_alu_ctrl = ALU_SLT;
          F3_SLTU:    w_alu_ctrl = ALU_SLTU;
          F3_XOR:     w_alu_ctrl = ALU_XOR;
          F3_SRL_SRA: w_alu_ctrl = funct7_in[5] ? ALU_SRA : ALU_SRL;
          F3_OR:      w_alu_ctrl = ALU_OR;
          F3_AND:     w_alu_ctrl = ALU_AND;
          default:    w_alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

  alu #(.XLEN(XLEN)) u_alu (
    .a        (w_fwd_a),
    .b        (w_op_b),
    .alu_ctrl (w_alu_ctrl),
    .result   (w_alu_result),
    .zero     (w_alu_zero)
  );

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, w_alu_zero, funct7_in[6], funct7_in[4:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_to_reg_out    <= 1'b0;
      reg_write_out     <= 1'b0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
      alu_result_out    <= '0;
      store_data_out    <= '0;
      rd_out            <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else begin
      alu_result_out    <= w_alu_result;
      store_data_out    <= w_fwd_b;
      branch_target_out <= pc_in + imm_in;
      // A flush turns this slot into a bubble; data lanes are don't-care.
      mem_to_reg_out    <= flush_in ? 1'b0 : mem_to_reg_in;
      reg_write_out     <= flush_in ? 1'b0 : reg_write_in;
      mem_read_out      <= flush_in ? 1'b0 : mem_read_in;
      mem_write_out     <= flush_in ? 1'b0 : mem_write_in;
      rd_out            <= flush_in ? '0 : rd_in;
      branch_taken_out  <= flush_in ? 1'b0 : (beq_in && (w_fwd_a == w_fwd_b));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Directed plus randomized self-checking bench for ex_mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
  logic        beq_in, alu_src_in;
  logic [1:0]  alu_op_in;
  logic [4:0]  rs1_in, rs2_in, rd_in, memwb_rd_in;
  logic [31:0] imm_in, reg_a_in, reg_b_in, pc_in, memwb_data_in;
  logic [6:0]  funct7_in;
  logic [2:0]  funct3_in;
  logic        memwb_reg_write_in;
  logic        mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out;
  logic [31:0] alu_result_out, store_data_out, branch_target_out;
  logic [4:0]  rd_out;
  logic        branch_taken_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .beq_in(beq_in), .alu_src_in(alu_src_in), .alu_op_in(alu_op_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .imm_in(imm_in),
    .reg_a_in(reg_a_in), .reg_b_in(reg_b_in), .funct7_in(funct7_in),
    .funct3_in(funct3_in), .pc_in(pc_in),
    .memwb_reg_write_in(memwb_reg_write_in), .memwb_rd_in(memwb_rd_in),
    .memwb_data_in(memwb_data_in),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .rd_out(rd_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out)
  );

  // Reference view of the EX/MEM register contents.
  typedef struct {
    logic        mtr, rw, mr, mw, bt;
    logic [31:0] alu, sd, tgt;
    logic [4:0]  rd;
  } exmem_t;

  exmem_t e;

  function automatic exmem_t zero_state();
    exmem_t z;
    z.mtr = 0; z.rw = 0; z.mr = 0; z.mw = 0; z.bt = 0;
    z.alu = 0; z.sd = 0; z.tgt = 0; z.rd = 0;
    return z;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (e.rw && !e.mr && e.rd != 0 && e.rd == rs) return e.alu;
    if (memwb_reg_write_in && memwb_rd_in != 0 && memwb_rd_in == rs) return memwb_data_in;
    return rf;
  endfunction

  function automatic logic [31:0] execute(input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    if (alu_op_in == 2'b00) return a + b;
    if (alu_op_in == 2'b01) return a - b;
    case (funct3_in)
      3'd0: return (alu_op_in == 2'b10 && funct7_in[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return funct7_in[5] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exmem_t predict();
    exmem_t n;
    logic [31:0] fa, fb;
    fa = operand(rs1_in, reg_a_in);
    fb = operand(rs2_in, reg_b_in);
    n.alu = execute(fa, alu_src_in ? imm_in : fb);
    n.sd  = fb;
    n.tgt = pc_in + imm_in;
    n.mtr = flush_in ? 1'b0 : mem_to_reg_in;
    n.rw  = flush_in ? 1'b0 : reg_write_in;
    n.mr  = flush_in ? 1'b0 : mem_read_in;
    n.mw  = flush_in ? 1'b0 : mem_write_in;
    n.rd  = flush_in ? 5'd0 : rd_in;
    n.bt  = flush_in ? 1'b0 : (beq_in && fa == fb);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    check({step, ".mem_to_reg"}, 32'(mem_to_reg_out), 32'(e.mtr));
    check({step, ".reg_write"},  32'(reg_write_out),  32'(e.rw));
    check({step, ".mem_read"},   32'(mem_read_out),   32'(e.mr));
    check({step, ".mem_write"},  32'(mem_write_out),  32'(e.mw));
    check({step, ".alu_result"}, alu_result_out,      e.alu);
    check({step, ".store_data"}, store_data_out,      e.sd);
    check({step, ".rd"},         32'(rd_out),         32'(e.rd));
    check({step, ".br_taken"},   32'(branch_taken_out), 32'(e.bt));
    check({step, ".br_target"},  branch_target_out,   e.tgt);
  endtask

  task automatic clear_inputs();
    flush_in = 0; mem_to_reg_in = 0; reg_write_in = 0; mem_read_in = 0;
    mem_write_in = 0; beq_in = 0; alu_src_in = 0; alu_op_in = 2'b00;
    rs1_in = 0; rs2_in = 0; rd_in = 0; imm_in = 0; reg_a_in = 0; reg_b_in = 0;
    funct7_in = 0; funct3_in = 0; pc_in = 0;
    memwb_reg_write_in = 0; memwb_rd_in = 0; memwb_data_in = 0;
  endtask

  // Advance one cycle: model and DUT both capture at the edge, check 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    e = predict();
    #1;
    check_all(tag);
  endtask

  task automatic alu_instr(input logic [4:0] rd, input logic [31:0] val, input logic is_load);
    clear_inputs();
    reg_write_in = 1; rd_in = rd; reg_a_in = val;
    mem_read_in = is_load; mem_to_reg_in = is_load;
  endtask

  initial begin
    e = zero_state();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // R-type SUB 10 - 3
    clear_inputs();
    reg_a_in = 10; reg_b_in = 3; alu_op_in = 2'b10; funct3_in = 3'b000; funct7_in = 7'b0100000;
    rs1_in = 1; rs2_in = 2; rd_in = 3; reg_write_in = 1;
    step("sub");
    check("sub.lit", alu_result_out, 32'd7);

    // SRA 0x80000000 >> 4
    clear_inputs();
    reg_a_in = 32'h8000_0000; reg_b_in = 4; alu_op_in = 2'b10; funct3_in = 3'b101;
    funct7_in = 7'b0100000; rs1_in = 8; rs2_in = 9;
    step("sra");
    check("sra.lit", alu_result_out, 32'hF800_0000);

    // Forwarding priority: EX/MEM x5=0x11 beats MEM/WB x5=0x22
    alu_instr(5'd5, 32'h11, 1'b0);
    step("fwd.setup");
    clear_inputs();
    rs1_in = 5; alu_src_in = 1; imm_in = 1; alu_op_in = 2'b11; funct3_in = 3'b000;
    memwb_reg_write_in = 1; memwb_rd_in = 5; memwb_data_in = 32'h22;
    step("fwd.prio");
    check("fwd.prio.lit", alu_result_out, 32'h12);

    // Writes to x0 never forward
    alu_instr(5'd0, 32'h11, 1'b0);
    step("x0.setup");
    clear_inputs();
    rs1_in = 0; reg_a_in = 32'h40; alu_src_in = 1; imm_in = 1; alu_op_in = 2'b11;
    memwb_reg_write_in = 1; memwb_rd_in = 0; memwb_data_in = 32'h22;
    step("x0.nofwd");
    check("x0.nofwd.lit", alu_result_out, 32'h41);

    // Load in EX/MEM is not forwarded
    alu_instr(5'd6, 32'h99, 1'b1);
    step("ld.setup");
    clear_inputs();
    rs2_in = 6; reg_b_in = 32'h1234; mem_write_in = 1; alu_src_in = 1;
    step("ld.nofwd");
    check("ld.nofwd.lit", store_data_out, 32'h1234);
    alu_instr(5'd6, 32'h99, 1'b1);
    step("ld.setup2");
    clear_inputs();
    rs2_in = 6; reg_b_in = 32'h1234; mem_write_in = 1; alu_src_in = 1;
    memwb_reg_write_in = 1; memwb_rd_in = 6; memwb_data_in = 32'hABCD;
    step("ld.memwb");
    check("ld.memwb.lit", store_data_out, 32'hABCD);

    // BEQ equal / unequal
    clear_inputs();
    pc_in = 32'h100; imm_in = 32'hFFFF_FFF8; reg_a_in = 42; reg_b_in = 42;
    rs1_in = 1; rs2_in = 2; beq_in = 1; alu_op_in = 2'b01;
    step("beq.eq");
    check("beq.eq.taken", 32'(branch_taken_out), 32'd1);
    check("beq.eq.target", branch_target_out, 32'hF8);
    reg_b_in = 43;
    step("beq.ne");
    check("beq.ne.taken", 32'(branch_taken_out), 32'd0);

    // Flush squashes control, rd and branch
    reg_b_in = 42; flush_in = 1; reg_write_in = 1; mem_write_in = 1; rd_in = 7;
    step("flush");
    check("flush.bt", 32'(branch_taken_out), 32'd0);
    check("flush.rw", 32'(reg_write_out), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      flush_in = ($urandom_range(0, 7) == 0);
      mem_to_reg_in = 1'($urandom); reg_write_in = 1'($urandom);
      mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
      beq_in = 1'($urandom); alu_src_in = 1'($urandom);
      alu_op_in = 2'($urandom);
      rs1_in = 5'($urandom_range(0, 7)); rs2_in = 5'($urandom_range(0, 7));
      rd_in = 5'($urandom_range(0, 7));
      imm_in = $urandom; pc_in = $urandom;
      reg_a_in = ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom;
      reg_b_in = ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom;
      funct7_in = ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'($urandom);
      funct3_in = 3'($urandom);
      memwb_reg_write_in = 1'($urandom);
      memwb_rd_in = 5'($urandom_range(0, 7));
      memwb_data_in = $urandom;
      step($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-cycle with busy inputs
    reg_write_in = 1; mem_write_in = 1; beq_in = 1; rd_in = 3; flush_in = 1;
    pc_in = 32'h200; imm_in = 32'h10; reg_a_in = 1; reg_b_in = 1;
    #3;
    reset = 1'b1;
    e = zero_state();
    #1;
    check_all("areset");
    @(posedge clk);
    #1;
    check_all("areset.hold");
    #3;
    reset = 1'b0;
    flush_in = 0;
    #1;
    check_all("areset.release");
    step("after.reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline; consumes ID/EX register outputs and produces the EX/MEM pipeline register.
- Contains ALU control decode, operand forwarding from EX/MEM and MEM/WB, the ALU, and BEQ compare and target computation.
- All results are registered into EX/MEM; the MEM stage uses branch_taken_out and branch_target_out to redirect the PC.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- flush_in  in  1  synchronous bubble insert into EX/MEM (taken branch resolved in MEM)
- mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_in, alu_src_in  in  1 each  control from ID/EX
- alu_op_in  in  2  00 add, 01 sub, 10 R-type, 11 I-type ALU
- rs1_in, rs2_in, rd_in  in  5  register indices from ID/EX
- imm_in  in  32  sign-extended immediate (B-type as byte offset)
- reg_a_in, reg_b_in  in  32  register file read data
- funct7_in  in  7
- funct3_in  in  3
- pc_in  in  32  PC of the instruction in EX
- memwb_reg_write_in  in  1  MEM/WB write enable
- memwb_rd_in  in  5  MEM/WB destination
- memwb_data_in  in  32  MEM/WB writeback value
- mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out  out  1 each  registered control
- alu_result_out  out  32  registered ALU result / memory address
- store_data_out  out  32  registered forwarded rs2 value
- rd_out  out  5  registered destination
- branch_taken_out  out  1  registered BEQ taken
- branch_target_out  out  32  registered pc_in + imm_in

Behaviour:
- Reset (async): every output is 0.
- Latency: 1 cycle. Inputs sampled at posedge; results are visible on the next cycle.
- Forward A:
  - If reg_write_out && !mem_read_out && rd_out!=0 && rd_out==rs1_in, use alu_result_out.
  - Else if memwb_reg_write_in && memwb_rd_in!=0 && memwb_rd_in==rs1_in, use memwb_data_in.
  - Else use reg_a_in.
  - EX/MEM has priority when both stages match.
- Forward B: same rules with rs2_in and reg_b_in.
- Load-use: forwarding from a load in EX/MEM is never performed. The hazard unit guarantees the stall.
- op_b = alu_src_in ? imm_in : fwd_b. store_data_out always captures fwd_b.
- ALU control:
  - alu_op 00 selects ADD; 01 selects SUB.
  - alu_op 10 decodes funct3/funct7[5]: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - alu_op 11 decodes the same table, except SUB is never selected (ADDI). funct7[5] still selects SRAI.
- Arithmetic: shifts use op_b[4:0]. SLT is signed and SLTU unsigned, result zero-extended to 32 bits. Add/sub wrap modulo 2^32.
- Branch: branch_taken_out <= beq_in && (fwd_a == fwd_b). branch_target_out <= pc_in + imm_in, modulo 2^32, captured every cycle.
- flush_in=1 at posedge clears reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, branch_taken_out and rd_out. Data outputs still capture normally.
- flush_in is ignored while reset is asserted. reset deasserted mid-pipeline restarts from all-zero outputs; no partial state persists.
- A write to x0 is never forwarded, even with reg_write set.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU_OP encodings (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_R=2'b10, ALUOP_I=2'b11).
  - The internal 4-bit alu_ctrl enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
  - The funct3 constants.
- One sub-module: alu (combinational; a, b, alu_ctrl -> result, zero).
- Forwarding and ALU control stay inline.

Test Plan:
- Reset: assert reset mid-cycle with non-zero inputs -> all outputs 0 immediately and held until the first posedge after release.
- R-type SUB: reg_a=10, reg_b=3, alu_op=10, funct3=000, funct7=0100000 -> alu_result_out=7 one cycle later; SRA of 0x80000000 by 4 -> 0xF8000000.
- Forwarding priority: rs1=5, both EX/MEM and MEM/WB write x5 (alu_result_out=0x11, memwb_data=0x22), ADDI imm=1 -> result 0x12. Same with rd=0 -> uses reg_a_in.
- Load no-forward: previous instruction in EX/MEM is a load to x6 (mem_read_out=1) and rs2=6 -> store_data_out=reg_b_in (or memwb_data_in if MEM/WB matches).
- BEQ: pc=0x100, imm=0xFFFFFFF8, fwd_a=fwd_b=42 -> branch_taken_out=1, branch_target_out=0xF8. Unequal operands -> branch_taken_out=0.
- Flush: flush_in=1 with reg_write_in=1, mem_write_in=1, beq taken -> next cycle all control outputs, branch_taken_out and rd_out are 0.
